// File: rtl/piarb_ll_walker_pkg.sv
// Shared PIARB constants and the walker state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef PIARB_BUF_PTR_NBITS
`define PIARB_BUF_PTR_NBITS 8
`endif

package piarb_ll_walker_pkg;

   // Buffer-pointer width, shared with the rest of PIARB.
   localparam int BUF_PTR_NBITS = `PIARB_BUF_PTR_NBITS;

   // Cycles from buf_req to buf_ack_valid in the linked-list storage.
   localparam int LL_RD_LAT = 3;

   // Walker FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } walk_state_t;

endpackage

// File: rtl/piarb_ll_walker_if.sv
// Bundles the walker's request, linked-list lookup and reader-side signals.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the reader; lookups are fixed-latency, no backpressure.
interface piarb_ll_walker_if
   import piarb_ll_walker_pkg::*;
#(
   parameter int BUF_NBITS = BUF_PTR_NBITS,
   parameter int CNT_NBITS = 6
) ();

   // Scheduler side.
   logic                 walk_req;
   logic [BUF_NBITS-1:0] walk_head_ptr;
   logic [CNT_NBITS-1:0] walk_nbuf;
   logic                 walk_ready;
   logic                 walk_done;

   // Linked-list storage side.
   logic                 buf_req;
   logic [BUF_NBITS-1:0] buf_req_ptr;
   logic                 buf_ack_valid;
   logic [BUF_NBITS-1:0] buf_ack_ptr;

   // Packet reader side.
   logic                 out_valid;
   logic [BUF_NBITS-1:0] out_buf_ptr;
   logic                 out_last;
   logic                 out_ready;

   logic                 walk_err;

   // The walker itself.
   modport master (
      input  walk_req, walk_head_ptr, walk_nbuf,
      output walk_ready, walk_done,
      output buf_req, buf_req_ptr,
      input  buf_ack_valid, buf_ack_ptr,
      output out_valid, out_buf_ptr, out_last,
      input  out_ready,
      output walk_err
   );

   // Everything around the walker (scheduler, list storage, reader).
   modport slave (
      output walk_req, walk_head_ptr, walk_nbuf,
      input  walk_ready, walk_done,
      input  buf_req, buf_req_ptr,
      output buf_ack_valid, buf_ack_ptr,
      input  out_valid, out_buf_ptr, out_last,
      output out_ready,
      input  walk_err
   );

endinterface

// File: rtl/piarb_ll_walker.sv
// Walks one packet's buffer chain: issues successor lookups and streams the pointers downstream.
// Latency: first pointer the cycle after walk_req is taken; best case one buffer every 4 cycles.
// Backpressure: out_* hold while out_ready=0; the lookup continues and its result parks in nxt_ptr.
// Optional: define PIARB_LL_WALK_TIMEOUT_EN for the lookup watchdog and the sticky walk_err flag.
module piarb_ll_walker
   import piarb_ll_walker_pkg::*;
#(
   parameter int BUF_NBITS      = BUF_PTR_NBITS,
   parameter int CNT_NBITS      = 6,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic               clk,
   input logic               rst_n,
   piarb_ll_walker_if.master bus
);

   walk_state_t          state;
   logic [BUF_NBITS-1:0] cur_ptr;
   logic [CNT_NBITS-1:0] rem;
   logic [BUF_NBITS-1:0] nxt_ptr;
   logic                 nxt_vld;
   logic                 req_pend;

   logic                 ack_hit;
   logic                 out_fire;
   logic [CNT_NBITS-1:0] rem_dec;
   logic                 ld_en;
   logic [BUF_NBITS-1:0] ld_ptr;
   logic                 timeout;

   // Decode handshakes and decide whether the next buffer is loaded this cycle.
   always_comb begin
      ack_hit  = bus.buf_ack_valid && req_pend;
      out_fire = bus.out_valid && bus.out_ready;
      rem_dec  = (rem != '0) ? rem - CNT_NBITS'(1) : rem;
      ld_en    = 1'b0;
      ld_ptr   = nxt_vld ? nxt_ptr : bus.buf_ack_ptr;
      case (state)
         // Bypass: an ack landing on the same cycle the reader takes the pointer is used directly.
         ST_EMIT: ld_en = !timeout && out_fire && !bus.out_last && (nxt_vld || ack_hit);
         ST_WAIT: begin
            ld_en  = !timeout && ack_hit;
            ld_ptr = bus.buf_ack_ptr;
         end
         default: ld_en = 1'b0;
      endcase
   end

   // Walker FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cur_ptr         <= '0;
         rem             <= '0;
         nxt_ptr         <= '0;
         nxt_vld         <= 1'b0;
         req_pend        <= 1'b0;
         bus.walk_ready  <= 1'b1;
         bus.walk_done   <= 1'b0;
         bus.buf_req     <= 1'b0;
         bus.buf_req_ptr <= '0;
         bus.out_valid   <= 1'b0;
         bus.out_buf_ptr <= '0;
         bus.out_last    <= 1'b0;
      end else begin
         bus.walk_done <= 1'b0;
         bus.buf_req   <= 1'b0;

         // Park a lookup result until the reader takes the current pointer.
         if (ack_hit) begin
            nxt_ptr  <= bus.buf_ack_ptr;
            nxt_vld  <= 1'b1;
            req_pend <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (bus.walk_req && bus.walk_ready) begin
                  if (bus.walk_nbuf == '0) begin
                     // Empty packet: acknowledge without emitting anything.
                     bus.walk_done <= 1'b1;
                  end else begin
                     state           <= ST_EMIT;
                     bus.walk_ready  <= 1'b0;
                     cur_ptr         <= bus.walk_head_ptr;
                     rem             <= bus.walk_nbuf;
                     nxt_vld         <= 1'b0;
                     bus.out_valid   <= 1'b1;
                     bus.out_buf_ptr <= bus.walk_head_ptr;
                     bus.out_last    <= (bus.walk_nbuf == CNT_NBITS'(1));
                     if (bus.walk_nbuf > CNT_NBITS'(1)) begin
                        bus.buf_req     <= 1'b1;
                        bus.buf_req_ptr <= bus.walk_head_ptr;
                        req_pend        <= 1'b1;
                     end
                  end
               end
            end
            ST_EMIT: begin
               if (!timeout && out_fire) begin
                  if (bus.out_last) begin
                     state         <= ST_DONE;
                     bus.out_valid <= 1'b0;
                     bus.out_last  <= 1'b0;
                     bus.walk_done <= 1'b1;
                  end else if (!ld_en) begin
                     // Successor not known yet: go quiet until the ack arrives.
                     state         <= ST_WAIT;
                     bus.out_valid <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               state <= ST_WAIT;
            end
            ST_DONE: begin
               state          <= ST_IDLE;
               bus.walk_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase

         // Advance to the next buffer in the chain and launch its own lookup if more follow.
         if (ld_en) begin
            state           <= ST_EMIT;
            cur_ptr         <= ld_ptr;
            rem             <= rem_dec;
            nxt_vld         <= 1'b0;
            bus.out_valid   <= 1'b1;
            bus.out_buf_ptr <= ld_ptr;
            bus.out_last    <= (rem_dec == CNT_NBITS'(1));
            if (rem_dec > CNT_NBITS'(1)) begin
               bus.buf_req     <= 1'b1;
               bus.buf_req_ptr <= ld_ptr;
               req_pend        <= 1'b1;
            end
         end

         // Lookup lost: close the packet on the current buffer so the reader sees an end marker.
         // out_last may change under backpressure here; this is an error path only.
         if (timeout) begin
            state           <= ST_EMIT;
            rem             <= CNT_NBITS'(1);
            nxt_vld         <= 1'b0;
            req_pend        <= 1'b0;
            bus.out_valid   <= 1'b1;
            bus.out_buf_ptr <= cur_ptr;
            bus.out_last    <= 1'b1;
         end
      end
   end

`ifdef PIARB_LL_WALK_TIMEOUT_EN
   localparam int TO_NBITS = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_NBITS-1:0] to_cnt;

   // to_cnt holds the number of cycles the current lookup has been outstanding (after its req cycle).
   assign timeout = req_pend && !bus.buf_req && !bus.buf_ack_valid &&
                    (to_cnt == TO_NBITS'(TIMEOUT_CYCLES - 1));

   // Ack watchdog and sticky error flag (timeout or ack with nothing outstanding).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt       <= '0;
         bus.walk_err <= 1'b0;
      end else begin
         if (bus.buf_req) begin
            to_cnt <= TO_NBITS'(1);
         end else if (!req_pend) begin
            to_cnt <= '0;
         end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_NBITS'(1);
         end
         if (timeout || (bus.buf_ack_valid && !req_pend)) begin
            bus.walk_err <= 1'b1;
         end
      end
   end
`else
   assign timeout      = 1'b0;
   assign bus.walk_err = 1'b0;
   wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_piarb_ll_walker.sv
// Directed bench for piarb_ll_walker: table of walks plus reset-mid-walk, stray-ack and timeout sequences.
// Latency: linked-list model answers LL_RD_LAT cycles after each buf_req.
// Backpressure: out_ready held low for a per-vector number of cycles.
module tb_piarb_ll_walker;
   import piarb_ll_walker_pkg::*;

   localparam int BW = BUF_PTR_NBITS;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   piarb_ll_walker_if #(.BUF_NBITS(BW), .CNT_NBITS(CW)) bus ();

   piarb_ll_walker #(.BUF_NBITS(BW), .CNT_NBITS(CW), .TIMEOUT_CYCLES(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- linked-list model ----------------
   logic [BW-1:0] ll_mem [0:(1<<BW)-1];
   logic [LL_RD_LAT:0] req_pipe;
   logic [BW-1:0] ptr_pipe [LL_RD_LAT+1];
   bit suppress_ack = 0;
   bit stray_go = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pipe = '0;
         bus.buf_ack_valid = 1'b0;
         bus.buf_ack_ptr = '0;
      end else begin
         #1;
         for (int i = LL_RD_LAT; i > 0; i--) begin
            req_pipe[i] = req_pipe[i-1];
            ptr_pipe[i] = ptr_pipe[i-1];
         end
         req_pipe[0] = bus.buf_req;
         ptr_pipe[0] = bus.buf_req_ptr;
         bus.buf_ack_valid = (req_pipe[LL_RD_LAT] && !suppress_ack) || stray_go;
         bus.buf_ack_ptr = stray_go ? BW'(8'h3F) : ll_mem[ptr_pipe[LL_RD_LAT]];
      end
   end

   // ---------------- monitor ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [BW-1:0] o_ptr [256];
   bit o_last [256];
   int o_cyc [256];
   logic [BW-1:0] r_ptr [256];
   int d_cyc [256];
   int n_out = 0, n_req = 0, n_done = 0, rdy_low = 0, stab_viol = 0;
   bit hold_pend = 0;
   logic [BW-1:0] h_ptr;
   bit h_last;

   always @(negedge clk) begin
      if (hold_pend && (bus.out_valid !== 1'b1 || bus.out_buf_ptr !== h_ptr || bus.out_last !== h_last))
         stab_viol++;
      hold_pend = bus.out_valid && !bus.out_ready;
      h_ptr = bus.out_buf_ptr;
      h_last = bus.out_last;
      if (bus.out_valid && bus.out_ready && n_out < 256) begin
         o_ptr[n_out] = bus.out_buf_ptr;
         o_last[n_out] = bus.out_last;
         o_cyc[n_out] = cyc;
         n_out++;
      end
      if (bus.buf_req && n_req < 256) begin
         r_ptr[n_req] = bus.buf_req_ptr;
         n_req++;
      end
      if (bus.walk_done && n_done < 256) begin
         d_cyc[n_done] = cyc;
         n_done++;
      end
      if (!bus.walk_ready) rdy_low++;
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [BW-1:0]       head;
      logic [CW-1:0]       nbuf;
      int                  bp;
      int                  nout;
      logic [3:0][BW-1:0]  ptr;
      int                  nreq;
      int                  gap0;
      int                  gap;
   } vec_t;

   vec_t vt [7];

   function automatic vec_t mkv(input logic [BW-1:0] head, input int nbuf, input int bp, input int nout,
                                input logic [BW-1:0] p0, input logic [BW-1:0] p1,
                                input logic [BW-1:0] p2, input logic [BW-1:0] p3,
                                input int nreq, input int gap0, input int gap);
      vec_t v;
      v.head = head; v.nbuf = CW'(nbuf); v.bp = bp; v.nout = nout;
      v.ptr = {p3, p2, p1, p0};
      v.nreq = nreq; v.gap0 = gap0; v.gap = gap;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string nm);
      int b_out, b_req, b_done, b_rdy, t0, k, got;
      @(negedge clk);
      b_out = n_out; b_req = n_req; b_done = n_done; b_rdy = rdy_low;
      bus.walk_req = 1'b1;
      bus.walk_head_ptr = v.head;
      bus.walk_nbuf = v.nbuf;
      bus.out_ready = (v.bp == 0);
      @(posedge clk);
      #1;
      bus.walk_req = 1'b0;
      t0 = cyc;
      repeat (v.bp) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      k = 0;
      while (n_done == b_done && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk({nm, " done_seen"}, 32'(n_done != b_done), 1);
      @(negedge clk);
      @(negedge clk);
      got = n_out - b_out;
      chk({nm, " n_out"}, got, v.nout);
      for (int i = 0; i < got && i < v.nout; i++) begin
         chk($sformatf("%s ptr[%0d]", nm, i), o_ptr[b_out+i], v.ptr[i]);
         chk($sformatf("%s last[%0d]", nm, i), 32'(o_last[b_out+i]), 32'(i == v.nout - 1));
         if (i == 0) chk({nm, " first_lat"}, o_cyc[b_out], t0 + v.bp);
         else chk($sformatf("%s gap[%0d]", nm, i), o_cyc[b_out+i] - o_cyc[b_out+i-1],
                  (i == 1) ? v.gap0 : v.gap);
      end
      chk({nm, " n_req"}, n_req - b_req, v.nreq);
      for (int i = 0; i < (n_req - b_req) && i < v.nreq; i++)
         chk($sformatf("%s req_ptr[%0d]", nm, i), r_ptr[b_req+i], v.ptr[i]);
      chk({nm, " n_done"}, n_done - b_done, 1);
      if (n_done != b_done)
         chk({nm, " done_cyc"}, d_cyc[b_done], (got > 0) ? o_cyc[n_out-1] + 1 : t0);
      if (v.nbuf == '0) chk({nm, " ready_stays"}, rdy_low - b_rdy, 0);
      chk({nm, " ready_after"}, 32'(bus.walk_ready), 1);
      chk({nm, " stable"}, stab_viol, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " walk_ready"}, 32'(bus.walk_ready), 1);
      chk({nm, " walk_done"}, 32'(bus.walk_done), 0);
      chk({nm, " buf_req"}, 32'(bus.buf_req), 0);
      chk({nm, " buf_req_ptr"}, 32'(bus.buf_req_ptr), 0);
      chk({nm, " out_valid"}, 32'(bus.out_valid), 0);
      chk({nm, " out_buf_ptr"}, 32'(bus.out_buf_ptr), 0);
      chk({nm, " out_last"}, 32'(bus.out_last), 0);
      chk({nm, " walk_err"}, 32'(bus.walk_err), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.walk_req = 1'b0;
      bus.walk_head_ptr = '0;
      bus.walk_nbuf = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < (1 << BW); i++) ll_mem[i] = '0;
      ll_mem[8'h05] = 8'h09; ll_mem[8'h09] = 8'h02; ll_mem[8'h02] = 8'h0C;
      ll_mem[8'h0C] = 8'h07; ll_mem[8'h07] = 8'h11; ll_mem[8'h30] = 8'h31;

      //        head   nbuf bp nout  p0     p1     p2     p3   nreq gap0 gap
      vt[0] = mkv(8'h05, 1, 0, 1, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      vt[1] = mkv(8'h05, 3, 0, 3, 8'h05, 8'h09, 8'h02, 8'h00, 2, 4, 4);
      vt[2] = mkv(8'h05, 3, 10, 3, 8'h05, 8'h09, 8'h02, 8'h00, 2, 1, 4);
      vt[3] = mkv(8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      vt[4] = mkv(8'h02, 4, 0, 4, 8'h02, 8'h0C, 8'h07, 8'h11, 3, 4, 4);
      vt[5] = mkv(8'h30, 2, 3, 2, 8'h30, 8'h31, 8'h00, 8'h00, 1, 1, 0);
      vt[6] = mkv(8'h30, 2, 2, 2, 8'h30, 8'h31, 8'h00, 8'h00, 1, 2, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // Reset while waiting for the first lookup.
      @(negedge clk);
      bus.walk_req = 1'b1; bus.walk_head_ptr = 8'h05; bus.walk_nbuf = 6'd3; bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.walk_req = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      chk("midwalk out_valid", 32'(bus.out_valid), 0);
      chk("midwalk walk_ready", 32'(bus.walk_ready), 0);
      chk("midwalk buf_req_ptr", 32'(bus.buf_req_ptr), 32'h05);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vec(vt[1], "post_rst");

`ifdef PIARB_LL_WALK_TIMEOUT_EN
      begin
         int b_out, k;
         chk("pre_to walk_err", 32'(bus.walk_err), 0);
         suppress_ack = 1'b1;
         b_out = n_out;
         @(negedge clk);
         bus.walk_req = 1'b1; bus.walk_head_ptr = 8'h05; bus.walk_nbuf = 6'd3; bus.out_ready = 1'b1;
         @(posedge clk); #1 bus.walk_req = 1'b0;
         k = 0;
         while (!bus.walk_done && k < 100) begin
            @(posedge clk); #1;
            k++;
         end
         chk("timeout done_seen", 32'(bus.walk_done), 1);
         chk("timeout walk_err", 32'(bus.walk_err), 1);
         chk("timeout n_out", n_out - b_out, 2);
         if (n_out - b_out == 2) begin
            chk("timeout ptr", o_ptr[b_out+1], 32'h05);
            chk("timeout last", 32'(o_last[b_out+1]), 1);
            chk("timeout lat", o_cyc[b_out+1] - o_cyc[b_out], 15);
         end
         suppress_ack = 1'b0;
         repeat (2) @(negedge clk);
      end
`endif

      // Ack with nothing outstanding must not disturb the next walk.
      @(negedge clk); stray_go = 1'b1;
      @(negedge clk); stray_go = 1'b0;
      repeat (2) @(negedge clk);
`ifdef PIARB_LL_WALK_TIMEOUT_EN
      chk("stray walk_err", 32'(bus.walk_err), 1);
`else
      chk("stray walk_err", 32'(bus.walk_err), 0);
`endif
      run_vec(vt[1], "post_stray");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
